// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and boot status of the loader.
// The loader sits on the slave side; the byte source / observer uses master.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_rst, load_done, load_err, words_loaded
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output cpu_rst, load_done, load_err, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses MAGIC/LEN/data/CHK frames, writes little-endian words into
// instruction memory and releases the core reset only after a clean checksum.
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [7:0]  MAGIC      = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus_io
);
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR} state_e;

    localparam logic [31:0] MAX_N = 32'd1 << ADDR_WIDTH;

    state_e      state_q, state_d;
    logic        ready_q;
    logic [15:0] len_q, len_d;
    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  chk_q, chk_d;
    logic [15:0] words_q, words_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        acc;
    logic [7:0]  rx;
    logic [15:0] len_full;

    assign acc      = bus_io.rx_valid & ready_q;
    assign rx       = bus_io.rx_data;
    assign len_full = {rx, len_q[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            len_q     <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            chk_q     <= '0;
            words_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= 1'b1;
            len_q     <= len_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            words_q   <= words_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (acc) begin
            case (state_q)
                IDLE, DONE, ERR: if (rx == MAGIC) state_d = LEN_LO;
                LEN_LO:          state_d = LEN_HI;
                LEN_HI: begin
                    if ({16'b0, len_full} > MAX_N) state_d = ERR;
                    else if (len_full == 16'd0)    state_d = CHECK;
                    else                           state_d = DATA;
                end
                DATA:  if (idx_q == 2'd3 && (words_q + 16'd1) == len_q) state_d = CHECK;
                CHECK: state_d = (rx == chk_q) ? DONE : ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        len_d     = len_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        words_d   = words_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;
        if (acc) begin
            case (state_q)
                LEN_LO: len_d = {len_q[15:8], rx};
                LEN_HI: begin
                    len_d   = len_full;
                    words_d = '0;
                    chk_d   = '0;
                    idx_d   = '0;
                end
                DATA: begin
                    chk_d = chk_q ^ rx;
                    idx_d = idx_q + 2'd1;
                    // Fourth byte completes the word; earlier bytes fill from the top down.
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {rx, shift_q};
                        addr_d  = BASE_ADDR + ({16'b0, words_q} << 2);
                        words_d = words_q + 16'd1;
                    end else begin
                        shift_d = {rx, shift_q[23:8]};
                    end
                end
                default: ;
            endcase
        end
        // Status flags follow the state being entered, one edge after the decision.
        if (state_d != state_q) begin
            case (state_d)
                LEN_LO: begin cpu_rst_d = 1'b1; done_d = 1'b0; err_d = 1'b0; end
                DONE:   begin cpu_rst_d = 1'b0; done_d = 1'b1; err_d = 1'b0; end
                ERR:    begin cpu_rst_d = 1'b1; done_d = 1'b0; err_d = 1'b1; end
                default: ;
            endcase
        end
    end

    assign bus_io.rx_ready     = ready_q;
    assign bus_io.imem_we      = we_q;
    assign bus_io.imem_addr    = addr_q;
    assign bus_io.imem_wdata   = wdata_q;
    assign bus_io.cpu_rst      = cpu_rst_q;
    assign bus_io.load_done    = done_q;
    assign bus_io.load_err     = err_q;
    assign bus_io.words_loaded = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame bench: frames are built word-by-word, expected writes go to a
// scoreboard queue and a separate monitor checks every write strobe against it.
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXN = 256;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    imem_loader_if bus();

    imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(BASE), .MAGIC(8'hA5)) dut (
        .clk(clk), .rst(rst), .bus_io(bus)
    );

    always #5 clk = ~clk;

    wr_t         exp_q[$];
    logic [31:0] fw[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          max_gap = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: every strobe must match the next expected write.
    always @(negedge clk) begin
        if (!rst && bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("we_addr", bus.imem_addr, e.a);
                chk("we_data", bus.imem_wdata, e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        while (bus.rx_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic c, input int w);
        chk({tag, "_done"},  32'(bus.load_done), 32'(d));
        chk({tag, "_err"},   32'(bus.load_err), 32'(e));
        chk({tag, "_cpurst"}, 32'(bus.cpu_rst), 32'(c));
        chk({tag, "_words"}, 32'(bus.words_loaded), 32'(w));
    endtask

    // Frame of n words; words come from fw first, then random. bad corrupts CHK.
    task automatic send_frame(input int n, input bit bad);
        logic [7:0]  c;
        logic [31:0] w;
        logic [15:0] nn;
        c  = 8'h00;
        nn = 16'(n);
        send_byte(8'hA5);
        chk("cpurst_after_magic", 32'(bus.cpu_rst), 32'd1);
        chk("done_clr_after_magic", 32'(bus.load_done), 32'd0);
        send_byte(nn[7:0]);
        send_byte(nn[15:8]);
        if (n > MAXN) begin
            check_status("oversize", 1'b0, 1'b1, 1'b1, 0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = (i < fw.size()) ? fw[i] : $urandom;
            exp_q.push_back('{a: BASE + 32'(4 * i), d: w});
            for (int k = 0; k < 4; k++) begin
                c ^= w[8*k +: 8];
                send_byte(w[8*k +: 8]);
            end
        end
        send_byte(bad ? (c ^ 8'h5C) : c);
        repeat (2) @(negedge clk);
        check_status(bad ? "badchk" : "good", !bad, bad, bad, n);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_addr", bus.imem_addr, BASE);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.rx_ready), 32'd1);

        // Two-instruction program, good then corrupted checksum
        fw = '{32'h0000_0013, 32'h0010_0093};
        send_frame(2, 1'b0);
        send_frame(2, 1'b1);
        fw.delete();

        // Garbage before an empty frame
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        send_frame(0, 1'b0);

        // Length one past capacity
        send_frame(MAXN + 1, 1'b0);

        // Single word with idle gaps between bytes
        max_gap = 3;
        send_frame(1, 1'b0);
        max_gap = 0;

        // Reset mid-word: first word lands, second is discarded
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        exp_q.push_back('{a: BASE, d: 32'hCAFE_F00D});
        send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
        send_byte(8'h11); send_byte(8'h22);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_we", 32'(bus.imem_we), 32'd0);
        check_status("abort", 1'b0, 1'b0, 1'b1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_frame(2, 1'b0);

        // Reload from DONE, then full-capacity frame
        send_frame(3, 1'b0);
        send_frame(MAXN, 1'b0);

        for (int r = 0; r < 5; r++) begin
            max_gap = $urandom_range(0, 2);
            send_frame(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end
        max_gap = 0;

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
